i2s_rx: RTL and testbench

- I2S receiver (slave) for the audio subsystem: captures stereo samples from an external I2S source (ADC / codec line-in).
- External master drives LRCK/BCK/DATA; all three are oversampled in the system clock domain.
- Presents one stereo pair per frame on parallel outputs with a one-cycle valid strobe. This is the receive-side counterpart to the existing I2S DAC transmitter.
- Bit format matches that transmitter: Philips I2S, MSB first, data delayed one BCK after the LRCK edge, LRCK low = left.

---
 rtl/audio_pkg.sv | 21 ++
 rtl/i2s_rx_if.sv | 47 ++++
 rtl/i2s_rx_sync_edge.sv | 50 +++++
 rtl/i2s_rx.sv | 224 ++++++++++++++++++++++
 tb/tb_i2s_rx.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the audio subsystem I2S blocks (receiver and the
// existing DAC transmitter).
//   AUDIO_SAMPLE_W : default sample width per channel
//   I2S_LEFT       : LRCK level that selects the left channel
//   i2s_rx_state_e : receiver frame-alignment state
// ---------------------------------------------------------------------------
package audio_pkg;

    localparam int AUDIO_SAMPLE_W = 24;

    localparam logic I2S_LEFT = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_rx_state_e;

endpackage

// File: rtl/i2s_rx_if.sv
// ---------------------------------------------------------------------------
// i2s_rx_if
// Bundles the serial I2S pins and the parallel stereo sample outputs of the
// receiver.
//   master : external source side (drives LRCK/BCK/DATA, observes samples)
//   slave  : receiver side (samples LRCK/BCK/DATA, drives sample outputs)
// Signals:
//   i2s_lrck, i2s_bck, i2s_data : asynchronous serial inputs
//   left_data, right_data       : last captured stereo pair (DATA_W each)
//   sample_valid                : one-clk strobe when a new pair is loaded
//   frame_err                   : pulses with sample_valid on a bad word length
// ---------------------------------------------------------------------------
interface i2s_rx_if
    import audio_pkg::*;
#(
    parameter int DATA_W = AUDIO_SAMPLE_W
);

    logic              i2s_lrck;
    logic              i2s_bck;
    logic              i2s_data;
    logic [DATA_W-1:0] left_data;
    logic [DATA_W-1:0] right_data;
    logic              sample_valid;
    logic              frame_err;

    modport master (
        output i2s_lrck,
        output i2s_bck,
        output i2s_data,
        input  left_data,
        input  right_data,
        input  sample_valid,
        input  frame_err
    );

    modport slave (
        input  i2s_lrck,
        input  i2s_bck,
        input  i2s_data,
        output left_data,
        output right_data,
        output sample_valid,
        output frame_err
    );

endinterface

// File: rtl/i2s_rx_sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
// Multi-flop synchronizer for asynchronous inputs. The edge input gets an
// extra history flop and a rising-edge strobe; the level inputs are only
// synchronized.
// Ports:
//   clk, rst_n : system clock, synchronous active-low reset
//   edge_i     : async input whose rising edge is detected (BCK)
//   level_i    : async inputs needing only synchronization (DATA, LRCK)
//   rise_o     : one-clk strobe on a synchronized rising edge of edge_i
//   level_o    : synchronized level_i
// SYNC_STAGES must be at least 2.
// ---------------------------------------------------------------------------
module sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter int LEVEL_W     = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               edge_i,
    input  logic [LEVEL_W-1:0] level_i,
    output logic               rise_o,
    output logic [LEVEL_W-1:0] level_o
);

    logic [SYNC_STAGES-1:0] edge_sync_q;
    logic                   edge_hist_q;
    logic [LEVEL_W-1:0]     level_sync_q [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            edge_sync_q <= '0;
            edge_hist_q <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                level_sync_q[i] <= '0;
            end
        end else begin
            edge_sync_q     <= {edge_sync_q[SYNC_STAGES-2:0], edge_i};
            edge_hist_q     <= edge_sync_q[SYNC_STAGES-1];
            level_sync_q[0] <= level_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                level_sync_q[i] <= level_sync_q[i-1];
            end
        end
    end

    assign rise_o  = edge_sync_q[SYNC_STAGES-1] & ~edge_hist_q;
    assign level_o = level_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_rx.sv
// ---------------------------------------------------------------------------
// i2s_rx
// I2S slave receiver: Philips format, MSB first, data one BCK after the LRCK
// edge, LRCK low = left. LRCK/BCK/DATA are oversampled in the clk domain
// (clk >= 4x BCK). One stereo pair is presented per frame with a one-clk
// sample_valid strobe.
// Ports:
//   clk          : system clock
//   rst_n        : synchronous active-low reset
//   enable       : capture enable, low forces IDLE (outputs hold)
//   bus (slave)  : i2s_lrck/i2s_bck/i2s_data in; left_data/right_data,
//                  sample_valid, frame_err out
// Build option:
//   I2S_RX_FRAME_CHECK_EN : when defined, per-channel true bit counters drive
//                           frame_err (pulses with sample_valid when either
//                           word of the pair was not DATA_W bits long).
//                           When undefined, frame_err is tied low.
// ---------------------------------------------------------------------------
module i2s_rx
    import audio_pkg::*;
#(
    parameter int DATA_W      = AUDIO_SAMPLE_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     enable,
    i2s_rx_if.slave  bus
);

    localparam int                CNT_W    = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic bck_rise;
    logic lrck_sync;
    logic data_sync;

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .LEVEL_W     (2)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .edge_i  (bus.i2s_bck),
        .level_i ({bus.i2s_data, bus.i2s_lrck}),
        .rise_o  (bck_rise),
        .level_o ({data_sync, lrck_sync})
    );

    i2s_rx_state_e     state_q, state_d;
    logic              lrck_prev_q, lrck_prev_d;   // LRCK at previous bck_rise
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sr_l_q, sr_l_d;
    logic [DATA_W-1:0] sr_r_q, sr_r_d;
    logic [DATA_W-1:0] left_hold_q, left_hold_d;
    logic              word_end_q, word_end_d;
    logic              to_left_q, to_left_d;
    logic [DATA_W-1:0] left_q, left_d;
    logic [DATA_W-1:0] right_q, right_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  bit_pos;

    // MSB lands at DATA_W-1; only evaluated while cnt_q < DATA_W.
    assign bit_pos = CNT_W'(DATA_W - 1) - cnt_q;

`ifdef I2S_RX_FRAME_CHECK_EN
    localparam logic [CNT_W-1:0] CNT_OVR = CNT_W'(DATA_W + 1);
    logic [CNT_W-1:0] cnt_l_q, cnt_l_d;
    logic [CNT_W-1:0] cnt_r_q, cnt_r_d;
    logic             err_q, err_d;
`endif

    always_comb begin
        state_d     = state_q;
        lrck_prev_d = lrck_prev_q;
        cnt_d       = cnt_q;
        sr_l_d      = sr_l_q;
        sr_r_d      = sr_r_q;
        left_hold_d = left_hold_q;
        word_end_d  = 1'b0;
        to_left_d   = to_left_q;
        left_d      = left_q;
        right_d     = right_q;
        valid_d     = 1'b0;
`ifdef I2S_RX_FRAME_CHECK_EN
        cnt_l_d     = cnt_l_q;
        cnt_r_d     = cnt_r_q;
        err_d       = 1'b0;
`endif

        // Stage 2: word end registered one clk earlier; the last bit of the
        // finished word is already in its shift register. lrck_prev_q now
        // names the channel of the word that is starting.
        if (word_end_q) begin
            cnt_d = '0;
            if (lrck_prev_q == I2S_LEFT) begin
                sr_l_d = '0;
`ifdef I2S_RX_FRAME_CHECK_EN
                cnt_l_d = '0;
`endif
            end else begin
                sr_r_d = '0;
`ifdef I2S_RX_FRAME_CHECK_EN
                cnt_r_d = '0;
`endif
            end

            case (state_q)
                IDLE: begin
                    if (to_left_q) begin
                        state_d = LEFT;
                    end
                end
                LEFT: begin
                    if (!to_left_q) begin
                        state_d     = RIGHT;
                        left_hold_d = sr_l_q;
                    end
                end
                RIGHT: begin
                    if (to_left_q) begin
                        state_d = LEFT;
                        left_d  = left_hold_q;
                        right_d = sr_r_q;
                        valid_d = 1'b1;
`ifdef I2S_RX_FRAME_CHECK_EN
                        err_d   = (cnt_l_q != CNT_FULL) || (cnt_r_q != CNT_FULL);
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Disabled: stay in IDLE, leave outputs untouched, suppress strobes.
        if (!enable) begin
            state_d     = IDLE;
            left_hold_d = left_hold_q;
            left_d      = left_q;
            right_d     = right_q;
            valid_d     = 1'b0;
`ifdef I2S_RX_FRAME_CHECK_EN
            err_d       = 1'b0;
`endif
        end

        // Stage 1: bit capture on the synchronized BCK rising edge. The bit
        // belongs to the channel LRCK selected at the previous rise.
        if (bck_rise) begin
            if (cnt_q != CNT_FULL) begin
                if (lrck_prev_q == I2S_LEFT) begin
                    sr_l_d = sr_l_q | (DATA_W'(data_sync) << bit_pos);
                end else begin
                    sr_r_d = sr_r_q | (DATA_W'(data_sync) << bit_pos);
                end
                cnt_d = cnt_q + CNT_ONE;
            end
`ifdef I2S_RX_FRAME_CHECK_EN
            if (lrck_prev_q == I2S_LEFT) begin
                if (cnt_l_q != CNT_OVR) cnt_l_d = cnt_l_q + CNT_ONE;
            end else begin
                if (cnt_r_q != CNT_OVR) cnt_r_d = cnt_r_q + CNT_ONE;
            end
`endif
            if (lrck_sync != lrck_prev_q) begin
                word_end_d  = 1'b1;
                to_left_d   = (lrck_sync == I2S_LEFT);
                lrck_prev_d = lrck_sync;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lrck_prev_q <= 1'b0;
            cnt_q       <= '0;
            sr_l_q      <= '0;
            sr_r_q      <= '0;
            left_hold_q <= '0;
            word_end_q  <= 1'b0;
            to_left_q   <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lrck_prev_q <= lrck_prev_d;
            cnt_q       <= cnt_d;
            sr_l_q      <= sr_l_d;
            sr_r_q      <= sr_r_d;
            left_hold_q <= left_hold_d;
            word_end_q  <= word_end_d;
            to_left_q   <= to_left_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
        end
    end

`ifdef I2S_RX_FRAME_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_l_q <= '0;
            cnt_r_q <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_l_q <= cnt_l_d;
            cnt_r_q <= cnt_r_d;
            err_q   <= err_d;
        end
    end

    assign bus.frame_err = err_q;
`else
    assign bus.frame_err = 1'b0;
`endif

    assign bus.left_data    = left_q;
    assign bus.right_data   = right_q;
    assign bus.sample_valid = valid_q;

endmodule

// File: tb/tb_i2s_rx.sv
// ---------------------------------------------------------------------------
// tb_i2s_rx
// Drives serial I2S frames into i2s_rx and compares every sample_valid pulse
// against pairs predicted from the transmitted words: a word's value is its
// first DATA_W bits left-justified, and a pair is reported only for frames
// whose left word begins after a high-to-low LRCK edge seen while the
// receiver was running.
// ---------------------------------------------------------------------------
module tb_i2s_rx;
    import audio_pkg::*;

    localparam int DW       = 24;
    localparam int SS       = 2;
    localparam int CLK_P    = 40;   // 25 MHz
    localparam int HALF_BCK = 8;    // BCK = clk/16 = 1.5625 MHz

    logic clk = 1'b0;
    logic rst_n;
    logic enable;

    i2s_rx_if #(.DATA_W(DW)) bus ();

    i2s_rx #(
        .DATA_W      (DW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .bus    (bus)
    );

    always #(CLK_P / 2) clk = ~clk;

    typedef struct packed {
        logic lrck;
        logic bit_v;
        logic en;
        logic rst;
        logic hold_chk;
    } period_t;

    period_t          stream [0:2047];
    int               slen;
    int               n_chk  = 0;
    int               n_fail = 0;
    logic [DW-1:0]    exp_l_q [$];
    logic [DW-1:0]    exp_r_q [$];
    logic             exp_e_q [$];
    logic [DW-1:0]    hold_l;
    logic [DW-1:0]    hold_r;
    time              last_hl_t = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // First DATA_W transmitted bits of a slot, zero padded when the slot is short.
    function automatic logic [DW-1:0] word_val(input logic [63:0] w, input int slot);
        logic [63:0] m;
        logic [63:0] t;
        m = (slot >= 64) ? {64{1'b1}} : ~({64{1'b1}} >> slot);
        t = w & m;
        return t[63 -: DW];
    endfunction

    function automatic logic word_err(input int ls, input int rs);
`ifdef I2S_RX_FRAME_CHECK_EN
        return (ls != DW) || (rs != DW);
`else
        return 1'b0;
`endif
    endfunction

    task automatic push_slot(input logic ch, input logic [63:0] w, input int slot);
        for (int i = 0; i < slot; i++) begin
            stream[slen] = '{lrck: ch, bit_v: w[63-i], en: 1'b1, rst: 1'b0, hold_chk: 1'b0};
            slen++;
        end
    endtask

    task automatic add_frame(input logic [63:0] wl, input int sl,
                             input logic [63:0] wr, input int sr, input bit expect_out);
        push_slot(I2S_LEFT, wl, sl);
        push_slot(~I2S_LEFT, wr, sr);
        if (expect_out) begin
            exp_l_q.push_back(word_val(wl, sl));
            exp_r_q.push_back(word_val(wr, sr));
            exp_e_q.push_back(word_err(sl, sr));
        end
    endtask

    // One left-channel period so the last right word is closed by an H->L edge.
    task automatic add_tail();
        stream[slen] = '{lrck: I2S_LEFT, bit_v: 1'b0, en: 1'b1, rst: 1'b0, hold_chk: 1'b0};
        slen++;
    endtask

    task automatic start_scn();
        rst_n        = 1'b0;
        enable       = 1'b1;
        bus.i2s_bck  = 1'b0;
        bus.i2s_lrck = I2S_LEFT;
        bus.i2s_data = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        slen = 0;
    endtask

    // Plays the stream: LRCK/DATA change with BCK falling, DATA lags by one BCK.
    task automatic play();
        logic prev;
        prev = 1'b0;
        @(negedge clk);
        for (int k = 0; k < slen; k++) begin
            rst_n        = ~stream[k].rst;
            enable       = stream[k].en;
            bus.i2s_bck  = 1'b0;
            bus.i2s_lrck = stream[k].lrck;
            bus.i2s_data = prev;
            prev         = stream[k].bit_v;
            repeat (HALF_BCK) @(negedge clk);
            if (stream[k].rst) begin
                chk("rst_left_data",    bus.left_data,    '0);
                chk("rst_right_data",   bus.right_data,   '0);
                chk("rst_sample_valid", bus.sample_valid, '0);
                chk("rst_frame_err",    bus.frame_err,    '0);
            end
            if (stream[k].hold_chk) begin
                chk("hold_left_data",  bus.left_data,  hold_l);
                chk("hold_right_data", bus.right_data, hold_r);
            end
            bus.i2s_bck = 1'b1;
            if (k > 0 && stream[k-1].lrck != I2S_LEFT && stream[k].lrck == I2S_LEFT)
                last_hl_t = $time;
            repeat (HALF_BCK) @(negedge clk);
        end
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (40) @(negedge clk);
        chk("pairs_outstanding", exp_l_q.size(), 0);
        exp_l_q.delete();
        exp_r_q.delete();
        exp_e_q.delete();
    endtask

    // Pulse monitor: value, latency from the pin BCK edge, and width.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.sample_valid === 1'b1) begin
                if (exp_l_q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    chk("left_data",  bus.left_data,  exp_l_q.pop_front());
                    chk("right_data", bus.right_data, exp_r_q.pop_front());
                    chk("frame_err",  bus.frame_err,  exp_e_q.pop_front());
                end
                chk("latency_clk", ($time - last_hl_t) / CLK_P, SS + 2);
                @(negedge clk);
                chk("pulse_width", bus.sample_valid, 0);
            end
        end
    end

    initial begin
        #(CLK_P * 95000);
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] wl, wr;
        logic [23:0] v24;
        int          sl, sr, base;

        rst_n        = 1'b0;
        enable       = 1'b1;
        bus.i2s_bck  = 1'b0;
        bus.i2s_lrck = I2S_LEFT;
        bus.i2s_data = 1'b0;
        slen         = 0;
        repeat (5) @(negedge clk);
        chk("reset_left_data",    bus.left_data,    '0);
        chk("reset_right_data",   bus.right_data,   '0);
        chk("reset_sample_valid", bus.sample_valid, '0);
        chk("reset_frame_err",    bus.frame_err,    '0);

        // Nominal: 32-bit slots, first frame discarded.
        start_scn();
        add_frame({24'h123456, 40'h0}, 32, {24'hABCDEF, 40'h0}, 32, 1'b0);
        add_frame({24'h123456, 40'h0}, 32, {24'hABCDEF, 40'h0}, 32, 1'b1);
        add_tail();
        play();

        // Short words: 16-bit slots.
        start_scn();
        for (int f = 0; f < 3; f++)
            add_frame({16'h8001, 48'h0}, 16, {16'h7FFF, 48'h0}, 16, f != 0);
        add_tail();
        play();

        // Long slots: 24 valid bits then 8 ones.
        start_scn();
        for (int f = 0; f < 3; f++) begin
            v24 = 24'($urandom);
            wl  = {v24, 8'hFF, 32'h0};
            v24 = 24'($urandom);
            wr  = {v24, 8'hFF, 32'h0};
            add_frame(wl, 32, wr, 32, f != 0);
        end
        add_tail();
        play();

        // Random slot lengths and contents.
        start_scn();
        for (int f = 0; f < 5; f++) begin
            wl = {$urandom, $urandom};
            wr = {$urandom, $urandom};
            sl = $urandom_range(8, 40);
            sr = $urandom_range(8, 40);
            if (f == 1) begin
                sl = DW;
                sr = DW;
            end
            add_frame(wl, sl, wr, sr, f != 0);
        end
        add_tail();
        play();

        // Reset during the left word of frame 3.
        start_scn();
        for (int f = 0; f < 5; f++) begin
            wl   = {$urandom, $urandom};
            wr   = {$urandom, $urandom};
            base = slen;
            add_frame(wl, DW, wr, DW, f == 1 || f == 3 || f == 4);
            if (f == 2) stream[base + 6].rst = 1'b1;
        end
        add_tail();
        play();

        // Enable dropped mid right word of frame 3, raised again before frame 4.
        start_scn();
        for (int f = 0; f < 5; f++) begin
            wl   = {$urandom, $urandom};
            wr   = {$urandom, $urandom};
            base = slen;
            add_frame(wl, DW, wr, DW, f == 1 || f == 3 || f == 4);
            if (f == 1) begin
                hold_l = word_val(wl, DW);
                hold_r = word_val(wr, DW);
            end
            if (f == 2) begin
                for (int i = 4; i < 16; i++) stream[base + DW + i].en = 1'b0;
                stream[base + DW + 8].hold_chk = 1'b1;
            end
            if (f == 3) stream[base + 10].hold_chk = 1'b1;
        end
        add_tail();
        play();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
